// File: rtl/telem_pkt_mon.sv
// telem_pkt_mon: 8N1 UART receiver feeding an AA 55 header / payload packet framer.
// Define TELEM_CKSUM_EN to require a modulo-256 checksum byte after the payload.
module telem_pkt_mon #(
    parameter int NUM_CH       = 3,
    parameter int DATA_W       = 12,
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RX,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     pkt_vld,
    output logic                     pkt_err,
    output logic [7:0]               err_cnt,
    output logic [7:0]               rx_byte,
    output logic                     rx_rdy
);
    localparam int BPC    = (DATA_W + 7) / 8;
    localparam int NB     = NUM_CH * BPC;
    localparam int SW     = 8 * NB;
    localparam int PW     = $clog2(SW);
    localparam int CW     = $clog2(BAUD_DIV);
    localparam int TO_LIM = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW     = $clog2(TO_LIM + 1);
    localparam int CHW    = $clog2(NUM_CH + 1);
    localparam int BKW    = $clog2(BPC + 1);

    // state   | meaning
    // RX_IDLE | line high, hunting a start bit
    // RX_START| waiting half a bit to re-check the start bit
    // RX_DATA | sampling 8 data bits, LSB first
    // RX_STOP | sampling the stop bit
    // RX_WAIT | after a frame error, waiting for the line to return high
    // HUNT1   | waiting for 0xAA
    // HUNT2   | seen 0xAA, waiting for 0x55
    // PAYLOAD | collecting NUM_CH*BPC payload bytes
    // CKSUM   | waiting for the checksum byte (TELEM_CKSUM_EN only)
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {
        HUNT1, HUNT2, PAYLOAD
`ifdef TELEM_CKSUM_EN
        , CKSUM
`endif
    } pkt_state_t;

    rx_state_t  r_rx_st, w_rx_nxt;
    pkt_state_t r_st, w_st_nxt;

    logic          r_rx_s1, r_rx_s2;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_byte;
    logic          r_rx_rdy;
    logic          w_tick, w_stop_smp, w_frm_err, w_byte_ok;

    assign w_tick     = (r_baud == '0);
    assign w_stop_smp = (r_rx_st == RX_STOP) && w_tick;
    assign w_frm_err  = w_stop_smp && !r_rx_s2;
    assign w_byte_ok  = w_stop_smp && r_rx_s2;

    always_comb begin
        w_rx_nxt = r_rx_st;
        case (r_rx_st)
            RX_IDLE:  if (!r_rx_s2) w_rx_nxt = RX_START;
            RX_START: if (w_tick) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_bit == 3'd7) w_rx_nxt = RX_STOP;
            RX_STOP:  if (w_tick) w_rx_nxt = r_rx_s2 ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (r_rx_s2) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rx_byte <= '0;
            r_rx_rdy  <= 1'b0;
        end else begin
            r_rx_s1  <= RX;
            r_rx_s2  <= r_rx_s1;
            r_rx_st  <= w_rx_nxt;
            r_rx_rdy <= w_byte_ok;
            if (w_byte_ok) r_rx_byte <= r_shift;
            case (r_rx_st)
                RX_IDLE: r_baud <= CW'(BAUD_DIV / 2 - 1);
                RX_START: begin
                    r_bit  <= '0;
                    r_baud <= w_tick ? CW'(BAUD_DIV - 1) : r_baud - CW'(1);
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_baud  <= CW'(BAUD_DIV - 1);
                    end else begin
                        r_baud <= r_baud - CW'(1);
                    end
                end
                RX_STOP: if (!w_tick) r_baud <= r_baud - CW'(1);
                default: ;
            endcase
        end
    end

    logic [NUM_CH*DATA_W-1:0] r_ch_data, w_ch_nxt;
    logic [SW-1:0]            r_stage, w_stage_nxt;
    logic [CHW-1:0]           r_ch;
    logic [BKW-1:0]           r_bk;
    logic [TW-1:0]            r_to_cnt;
    logic [7:0]               r_err_cnt;
    logic                     r_pkt_vld, r_pkt_err;
    logic [PW-1:0]            w_bpos;
    logic                     w_in_pkt, w_to, w_last;
    logic                     w_abort, w_done, w_store, w_clr;
`ifdef TELEM_CKSUM_EN
    logic [7:0]               r_sum;
    assign w_in_pkt = (r_st == PAYLOAD) || (r_st == CKSUM);
`else
    assign w_in_pkt = (r_st == PAYLOAD);
`endif
    assign w_to   = w_in_pkt && (r_to_cnt == '0) && !r_rx_rdy;
    assign w_last = (r_ch == CHW'(NUM_CH - 1)) && (r_bk == BKW'(BPC - 1));
    // MSB byte of each channel arrives first, so it lands at the top of that channel's slot
    assign w_bpos = PW'((int'(r_ch) * BPC + (BPC - 1 - int'(r_bk))) * 8);

    always_comb begin
        w_st_nxt = r_st;
        w_abort  = 1'b0;
        w_done   = 1'b0;
        w_store  = 1'b0;
        w_clr    = 1'b0;
        case (r_st)
            HUNT1: if (r_rx_rdy && r_rx_byte == 8'hAA) w_st_nxt = HUNT2;
            HUNT2: begin
                if (r_rx_rdy) begin
                    if (r_rx_byte == 8'h55) begin
                        w_st_nxt = PAYLOAD;
                        w_clr    = 1'b1;
                    end else if (r_rx_byte != 8'hAA) begin
                        w_st_nxt = HUNT1;
                    end
                end
            end
            PAYLOAD: begin
                if (w_frm_err || w_to) begin
                    w_abort  = 1'b1;
                    w_st_nxt = HUNT1;
                end else if (r_rx_rdy) begin
                    w_store = 1'b1;
                    if (w_last) begin
`ifdef TELEM_CKSUM_EN
                        w_st_nxt = CKSUM;
`else
                        w_done   = 1'b1;
                        w_st_nxt = HUNT1;
`endif
                    end
                end
            end
`ifdef TELEM_CKSUM_EN
            CKSUM: begin
                if (w_frm_err || w_to) begin
                    w_abort  = 1'b1;
                    w_st_nxt = HUNT1;
                end else if (r_rx_rdy) begin
                    w_done   = (r_rx_byte == r_sum);
                    w_abort  = (r_rx_byte != r_sum);
                    w_st_nxt = HUNT1;
                end
            end
`endif
            default: w_st_nxt = HUNT1;
        endcase
    end

    always_comb begin
        w_stage_nxt = r_stage;
        if (w_store) w_stage_nxt[w_bpos +: 8] = r_rx_byte;
        w_ch_nxt = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_ch_nxt[c*DATA_W +: DATA_W] = w_stage_nxt[c*8*BPC +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st      <= HUNT1;
            r_ch_data <= '0;
            r_stage   <= '0;
            r_ch      <= '0;
            r_bk      <= '0;
            r_to_cnt  <= '0;
            r_err_cnt <= '0;
            r_pkt_vld <= 1'b0;
            r_pkt_err <= 1'b0;
`ifdef TELEM_CKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_st      <= w_st_nxt;
            r_pkt_vld <= w_done;
            r_pkt_err <= w_abort;
            r_stage   <= w_stage_nxt;
            if (w_abort && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (r_rx_rdy)             r_to_cnt <= TW'(TO_LIM);
            else if (r_to_cnt != '0)  r_to_cnt <= r_to_cnt - TW'(1);
            if (w_clr) begin
                r_ch <= '0;
                r_bk <= '0;
`ifdef TELEM_CKSUM_EN
                r_sum <= '0;
`endif
            end else if (w_store) begin
`ifdef TELEM_CKSUM_EN
                r_sum <= r_sum + r_rx_byte;
`endif
                if (r_bk == BKW'(BPC - 1)) begin
                    r_bk <= '0;
                    r_ch <= r_ch + CHW'(1);
                end else begin
                    r_bk <= r_bk + BKW'(1);
                end
            end
            if (w_done) r_ch_data <= w_ch_nxt;
        end
    end

    assign ch_data = r_ch_data;
    assign pkt_vld = r_pkt_vld;
    assign pkt_err = r_pkt_err;
    assign err_cnt = r_err_cnt;
    assign rx_byte = r_rx_byte;
    assign rx_rdy  = r_rx_rdy;
endmodule

// File: tb/tb_telem_pkt_mon.sv
// Scoreboard bench for telem_pkt_mon at BAUD_DIV=8: stimulus pushes expected bytes,
// packets and aborts into queues; a negedge monitor pops and compares them.
module tb_telem_pkt_mon;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 12;
    localparam int BAUD   = 8;
    localparam int NB     = 6;
    localparam int CHDW   = NUM_CH * DATA_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            RX  = 1'b1;
    logic [CHDW-1:0] ch_data;
    logic            pkt_vld, pkt_err, rx_rdy;
    logic [7:0]      err_cnt, rx_byte;

    telem_pkt_mon #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BAUD_DIV(BAUD), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst(rst), .RX(RX), .ch_data(ch_data), .pkt_vld(pkt_vld),
        .pkt_err(pkt_err), .err_cnt(err_cnt), .rx_byte(rx_byte), .rx_rdy(rx_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]      exp_byte_q[$];
    logic [CHDW-1:0] exp_pkt_q[$];
    int              exp_err_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) exp_byte_q.push_back(b);
        RX = 1'b0;
        idle(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(BAUD);
        end
        RX = stop;
        idle(BAUD);
        RX = 1'b1;
    endtask

    task automatic send_pkt(input logic [8*NB-1:0] pl, input logic [CHDW-1:0] expv);
        logic [7:0] sum;
        sum = 8'h00;
        exp_pkt_q.push_back(expv);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        for (int i = 0; i < NB; i++) begin
            send_byte(pl[8*(NB-1-i) +: 8], 1'b1);
            sum = sum + pl[8*(NB-1-i) +: 8];
        end
`ifdef TELEM_CKSUM_EN
        send_byte(sum, 1'b1);
`endif
        idle(20);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ch_data"}, ch_data, 0);
        check({tag, " pkt_vld"}, pkt_vld, 0);
        check({tag, " pkt_err"}, pkt_err, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
        check({tag, " rx_byte"}, rx_byte, 0);
        check({tag, " rx_rdy"},  rx_rdy,  0);
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rx_rdy) begin
                if (exp_byte_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_rdy: unexpected byte %h, none expected", rx_byte);
                end else begin
                    check("rx_byte", rx_byte, exp_byte_q.pop_front());
                end
            end
            if (pkt_vld) begin
                if (exp_pkt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pkt_vld: unexpected packet %h, none expected", ch_data);
                end else begin
                    check("ch_data", ch_data, exp_pkt_q.pop_front());
                end
            end
            if (pkt_err) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    errors++;
                    $display("FAIL pkt_err: asserted, required 0 (err_cnt %0d)", err_cnt);
                end else begin
                    void'(exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RX  = 1'b1;
        rst = 1'b1;
        idle(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(10);

        // basic packet
        send_pkt(48'h0ABC_0123_0FFF, {12'hFFF, 12'h123, 12'hABC});
        check("t1 ch_data", ch_data, {12'hFFF, 12'h123, 12'hABC});
        check("t1 err_cnt", err_cnt, 0);

        // junk and repeated AA before the header
        send_byte(8'h12, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_pkt(48'h0102_0304_0506, {12'h506, 12'h304, 12'h102});
        check("t2 err_cnt", err_cnt, 0);

        // frame error on the 3rd payload byte
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        exp_err_q.push_back(1);
        send_byte(8'h01, 1'b0);
        idle(40);
        check("t3 err_cnt", err_cnt, 1);
        check("t3 ch_data kept", ch_data, {12'h506, 12'h304, 12'h102});
        send_pkt(48'h0011_0F22_0833, {12'h833, 12'hF22, 12'h011});

        // false start glitch
        RX = 1'b0;
        idle(2);
        RX = 1'b1;
        idle(40);
        check("glitch err_cnt", err_cnt, 1);

        // inter-byte timeout after the 2nd payload byte
        for (int r = 0; r < 2; r++) begin
            send_byte(8'hAA, 1'b1);
            send_byte(8'h55, 1'b1);
            send_byte(8'h01, 1'b1);
            send_byte(8'h02, 1'b1);
            exp_err_q.push_back(1);
            idle(21 * BAUD);
        end
        check("t4 err_cnt", err_cnt, 3);
        check("t4 ch_data kept", ch_data, {12'h833, 12'hF22, 12'h011});
        send_pkt(48'h0777_0888_0999, {12'h999, 12'h888, 12'h777});

        // saturation
        for (int r = 0; r < 255; r++) begin
            send_byte(8'hAA, 1'b1);
            send_byte(8'h55, 1'b1);
            exp_err_q.push_back(1);
            send_byte(8'h00, 1'b0);
            idle(4);
        end
        idle(10);
        check("sat err_cnt", err_cnt, 255);

        // reset mid-payload
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        RX = 1'b0;
        idle(20);
        rst = 1'b1;
        RX  = 1'b1;
        idle(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        idle(30);
        check("post-rst pkt_err count", err_cnt, 0);
        send_pkt(48'h0FED_0CBA_0987, {12'h987, 12'hCBA, 12'hFED});

`ifdef TELEM_CKSUM_EN
        exp_pkt_q.push_back({12'h506, 12'h304, 12'h102});
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h15, 1'b1);
        idle(20);
        check("cksum ok ch_data", ch_data, {12'h506, 12'h304, 12'h102});
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        exp_err_q.push_back(1);
        send_byte(8'h16, 1'b1);
        idle(20);
        check("cksum bad err_cnt", err_cnt, 1);
`endif

        idle(20);
        check("pending bytes",   exp_byte_q.size(), 0);
        check("pending packets", exp_pkt_q.size(),  0);
        check("pending aborts",  exp_err_q.size(),  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
